// File: rtl/ahb_sram_bridge.sv
//==============================================================================
// Module      : ahb_sram_bridge
// Description : AHB-Lite slave to single-port synchronous SRAM bridge with
//               zero-wait reads/writes and one-wait write-then-read collisions.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ahb_sram_bridge #(
    parameter int AW = 12
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic [31:0]   HRDATA,
    input  logic [31:0]   SRAMRDATA,
    output logic [3:0]    SRAMWEN,
    output logic [31:0]   SRAMWDATA,
    output logic          SRAMCS0,
    output logic [AW-1:0] SRAMADDR
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WR_DATA  = 3'd1,
        S_RD_DATA  = 3'd2,
        S_RD_STALL = 3'd3,
        S_ERR1     = 3'd4,
        S_ERR2     = 3'd5
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_mask;

    logic          w_open;
    logic          w_accept;
    logic          w_illegal;
    logic [3:0]    w_mask;
    logic [AW-1:0] w_word;
    logic          w_unused;

    assign w_word   = HADDR[AW+1:2];
    assign w_unused = &{1'b0, HADDR[31:AW+2], HTRANS[0]};

    // New transfers are only taken in states that present HREADYOUT=1.
    assign w_open   = (r_state == S_IDLE) || (r_state == S_WR_DATA) ||
                      (r_state == S_RD_DATA) || (r_state == S_ERR2);
    assign w_accept = HSEL && HTRANS[1] && HREADY && w_open && !HRESET;

    assign w_illegal = (HSIZE > 3'd2) ||
                       ((HSIZE == 3'd1) && HADDR[0]) ||
                       ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

    always_comb begin
        w_mask = 4'b0000;
        case (HSIZE)
            3'd0:    w_mask = 4'b0001 << HADDR[1:0];
            3'd1:    w_mask = HADDR[1] ? 4'b1100 : 4'b0011;
            3'd2:    w_mask = 4'b1111;
            default: w_mask = 4'b0000;
        endcase
    end

    always_comb begin
        w_next = S_IDLE;
        case (r_state)
            S_RD_STALL: w_next = S_RD_DATA;
            S_ERR1:     w_next = S_ERR2;
            default: begin
                if (w_accept) begin
                    if (w_illegal)
                        w_next = S_ERR1;
                    else if (HWRITE)
                        w_next = S_WR_DATA;
                    else if (r_state == S_WR_DATA)
                        w_next = S_RD_STALL;
                    else
                        w_next = S_RD_DATA;
                end
            end
        endcase
    end

    // r_addr holds either the pending write address or a read deferred by a
    // write data phase; the write has already used it by the time it changes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_mask  <= 4'b0000;
        end else begin
            r_state <= w_next;
            if (w_accept && !w_illegal) begin
                r_addr <= w_word;
                r_mask <= HWRITE ? w_mask : 4'b0000;
            end
        end
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        SRAMCS0   = 1'b0;
        SRAMWEN   = 4'b0000;
        SRAMADDR  = r_addr;
        case (r_state)
            S_WR_DATA: begin
                SRAMCS0 = 1'b1;
                SRAMWEN = r_mask;
            end
            S_RD_STALL: begin
                SRAMCS0   = 1'b1;
                HREADYOUT = 1'b0;
            end
            S_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = 1'b1;
            end
            S_ERR2: HRESP = 1'b1;
            default: ;
        endcase
        // Zero-wait read: strobe straight from the address phase when the
        // SRAM port is not busy with a write.
        if (w_accept && !w_illegal && !HWRITE && (r_state != S_WR_DATA)) begin
            SRAMCS0  = 1'b1;
            SRAMWEN  = 4'b0000;
            SRAMADDR = w_word;
        end
    end

    assign SRAMWDATA = HWDATA;
    assign HRDATA    = SRAMRDATA;

endmodule

`default_nettype wire

// File: tb/tb_ahb_sram_bridge.sv
//==============================================================================
// Module      : tb_ahb_sram_bridge
// Description : Directed self-checking bench for ahb_sram_bridge with an
//               SRAM device model and a transfer-level expectation model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ahb_sram_bridge;

    localparam int AW = 12;

    logic          HCLK, HRESET, HSEL, HWRITE, HREADY, HREADYOUT, HRESP, SRAMCS0;
    logic [31:0]   HADDR, HWDATA, HRDATA, SRAMRDATA, SRAMWDATA;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic [3:0]    SRAMWEN;
    logic [AW-1:0] SRAMADDR;

    ahb_sram_bridge #(.AW(AW)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR),
        .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA),
        .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
        .SRAMRDATA(SRAMRDATA), .SRAMWEN(SRAMWEN), .SRAMWDATA(SRAMWDATA),
        .SRAMCS0(SRAMCS0), .SRAMADDR(SRAMADDR)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    // Single slave on the bus: the mux returns our own ready.
    assign HREADY = HREADYOUT;

    logic [31:0] sram    [0:(1<<AW)-1];
    logic [31:0] exp_mem [0:(1<<AW)-1];

    always @(posedge HCLK) begin
        if (SRAMCS0) begin
            if (SRAMWEN != 4'b0000) begin
                for (int b = 0; b < 4; b++)
                    if (SRAMWEN[b]) sram[SRAMADDR][8*b +: 8] <= SRAMWDATA[8*b +: 8];
            end else begin
                SRAMRDATA <= sram[SRAMADDR];
            end
        end
    end

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        has_lit;
        logic [31:0] lit;
    } xfer_t;

    xfer_t q[$];
    int    checks = 0;
    int    errors = 0;

    xfer_t a, dp;
    logic  a_v, dp_v, dp_stall;
    int    dp_cyc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic sel, input logic [1:0] tr, input logic wr,
                       input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic has_lit, input logic [31:0] lit);
        xfer_t t;
        t.sel = sel; t.trans = tr; t.wr = wr; t.sz = sz; t.addr = addr;
        t.wdata = wdata; t.has_lit = has_lit; t.lit = lit;
        q.push_back(t);
    endtask

    function automatic logic illegal(input xfer_t t);
        return (t.sz > 3'd2) || (t.sz == 3'd1 && t.addr[0]) ||
               (t.sz == 3'd2 && t.addr[1:0] != 2'b00);
    endfunction

    function automatic logic [3:0] lanes(input xfer_t t);
        case (t.sz)
            3'd0:    return 4'b0001 << t.addr[1:0];
            3'd1:    return t.addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [AW-1:0] word_of(input logic [31:0] addr);
        return addr[AW+1:2];
    endfunction

    function automatic int waits_of(input xfer_t t, input logic stall);
        return (illegal(t) || stall) ? 1 : 0;
    endfunction

    // Expectations for one cycle, derived from the transfer in its data phase,
    // how long it has been there, and the transfer offered in the address phase.
    task automatic check_cycle();
        logic       exp_ready, exp_cs;
        logic [3:0] exp_wen;
        logic [AW-1:0] exp_addr;
        logic       dp_legal;
        dp_legal  = dp_v && !illegal(dp);
        exp_ready = !dp_v || (dp_cyc >= waits_of(dp, dp_stall));
        chk("hreadyout", HREADYOUT, exp_ready);
        chk("hresp", HRESP, dp_v && illegal(dp));
        exp_cs = 1'b0; exp_wen = 4'b0000; exp_addr = '0;
        if (dp_legal && dp.wr) begin
            exp_cs = 1'b1; exp_wen = lanes(dp); exp_addr = word_of(dp.addr);
            chk("wr_wdata", SRAMWDATA, dp.wdata);
            if (dp.has_lit) chk("wr_wen_addr_lit", {16'h0, SRAMWEN, SRAMADDR}, dp.lit);
        end else if (dp_legal && dp_stall && dp_cyc == 0) begin
            exp_cs = 1'b1; exp_addr = word_of(dp.addr);
        end else if (exp_ready && a_v && a.sel && a.trans[1] && !illegal(a) && !a.wr) begin
            exp_cs = 1'b1; exp_addr = word_of(a.addr);
        end
        chk("sram_cs", SRAMCS0, exp_cs);
        chk("sram_wen", SRAMWEN, exp_wen);
        if (exp_cs) chk("sram_addr", SRAMADDR, exp_addr);
        if (dp_legal && !dp.wr && exp_ready) begin
            chk("hrdata", HRDATA, exp_mem[word_of(dp.addr)]);
            if (dp.has_lit) chk("model_rd_lit", exp_mem[word_of(dp.addr)], dp.lit);
        end
    endtask

    task automatic idle_bus();
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h0;
    endtask

    initial begin
        int  idx;
        logic rdy;
        for (int i = 0; i < (1<<AW); i++) begin
            sram[i]    = 32'hC0DE0000 | i;
            exp_mem[i] = 32'hC0DE0000 | i;
        end
        SRAMRDATA = 32'h0;
        HWDATA = 32'h0;
        idle_bus();
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_hreadyout", HREADYOUT, 1'b1);
        chk("rst_hresp", HRESP, 1'b0);
        chk("rst_cs", SRAMCS0, 1'b0);
        chk("rst_wen", SRAMWEN, 4'b0000);
        chk("rst_addr", SRAMADDR, '0);
        @(posedge HCLK); #1;
        HRESET = 1'b0;

        add(1, 2'b10, 1, 3'd2, 32'h0000_0010, 32'h1234_5678, 1, 32'h0000_F004);
        add(1, 2'b00, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0);
        add(1, 2'b10, 0, 3'd2, 32'h0000_0010, 32'h0, 1, 32'h1234_5678);
        add(1, 2'b10, 1, 3'd0, 32'h0000_0013, 32'hAB00_0000, 1, 32'h0000_8004);
        add(1, 2'b11, 1, 3'd1, 32'h0000_0016, 32'hCDEF_0000, 1, 32'h0000_C005);
        add(1, 2'b00, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0);
        add(1, 2'b10, 0, 3'd2, 32'h0000_0010, 32'h0, 1, 32'hAB34_5678);
        add(1, 2'b10, 1, 3'd2, 32'h0000_0020, 32'hA5A5_A5A5, 1, 32'h0000_F008);
        add(1, 2'b10, 0, 3'd2, 32'h0000_0020, 32'h0, 1, 32'hA5A5_A5A5);
        add(1, 2'b10, 0, 3'd2, 32'h0000_0002, 32'h0, 0, 32'h0);
        add(1, 2'b10, 1, 3'd2, 32'h0000_4000, 32'h0BAD_F00D, 1, 32'h0000_F000);
        add(1, 2'b10, 0, 3'd2, 32'h0000_0000, 32'h0, 1, 32'h0BAD_F00D);
        add(1, 2'b11, 0, 3'd2, 32'h0000_0010, 32'h0, 1, 32'hAB34_5678);
        add(0, 2'b10, 0, 3'd0, 32'h0000_0003, 32'h0, 0, 32'h0);
        add(1, 2'b01, 1, 3'd2, 32'h0000_0004, 32'h0, 0, 32'h0);
        add(1, 2'b10, 1, 3'd1, 32'h0000_0015, 32'h1111_1111, 0, 32'h0);
        add(1, 2'b10, 0, 3'd3, 32'h0000_0000, 32'h0, 0, 32'h0);
        add(1, 2'b10, 0, 3'd1, 32'h0000_0016, 32'h0, 1, 32'hCDEF_0005);
        add(1, 2'b10, 1, 3'd0, 32'h0000_0001, 32'h0000_3300, 1, 32'h0000_2000);
        add(1, 2'b10, 0, 3'd0, 32'h0000_0000, 32'h0, 1, 32'h0BAD_330D);
        add(1, 2'b00, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0);

        idx = 0; dp_v = 1'b0; dp_cyc = 0; dp_stall = 1'b0;
        for (int guard = 0; guard < 400 && (idx < q.size() || dp_v); guard++) begin
            a_v = (idx < q.size());
            if (a_v) begin
                a = q[idx];
                HSEL = a.sel; HTRANS = a.trans; HWRITE = a.wr; HSIZE = a.sz; HADDR = a.addr;
            end else begin
                idle_bus();
            end
            HWDATA = (dp_v && dp.wr) ? dp.wdata : 32'h0;
            @(negedge HCLK);
            check_cycle();
            rdy = HREADYOUT;
            @(posedge HCLK); #1;
            if (rdy) begin
                if (dp_v) begin
                    chk("wait_states", dp_cyc, waits_of(dp, dp_stall));
                    if (!illegal(dp) && dp.wr)
                        for (int b = 0; b < 4; b++)
                            if (lanes(dp)[b])
                                exp_mem[word_of(dp.addr)][8*b +: 8] = dp.wdata[8*b +: 8];
                end
                if (a_v && a.sel && a.trans[1]) begin
                    dp_stall = !illegal(a) && !a.wr && dp_v && !illegal(dp) && dp.wr;
                    dp = a;
                    dp_v = 1'b1;
                end else begin
                    dp_v = 1'b0;
                    dp_stall = 1'b0;
                end
                dp_cyc = 0;
                if (a_v) idx++;
            end else begin
                dp_cyc++;
            end
        end
        chk("vector_run_complete", (idx == q.size() && !dp_v), 1'b1);
        chk("model_byte_merge_lit", exp_mem[4], 32'hAB34_5678);

        // Reset asserted while a collided read sits in its wait state.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2; HADDR = 32'h40;
        @(negedge HCLK); @(posedge HCLK); #1;
        HWRITE = 1'b0; HADDR = 32'h40; HWDATA = 32'h0000_0055;
        @(negedge HCLK);
        chk("rstseq_wr_cs", SRAMCS0, 1'b1);
        chk("rstseq_wr_wen", SRAMWEN, 4'hF);
        @(posedge HCLK); #1;
        idle_bus(); HWDATA = 32'h0;
        @(negedge HCLK);
        chk("rstseq_stall_ready", HREADYOUT, 1'b0);
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0;
        @(negedge HCLK);
        chk("rstseq_after_ready", HREADYOUT, 1'b1);
        chk("rstseq_after_cs", SRAMCS0, 1'b0);
        chk("rstseq_after_wen", SRAMWEN, 4'h0);
        @(posedge HCLK); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2; HADDR = 32'h0;
        @(negedge HCLK);
        chk("rstseq_rd_cs", SRAMCS0, 1'b1);
        chk("rstseq_rd_addr", SRAMADDR, '0);
        @(posedge HCLK); #1;
        idle_bus();
        @(negedge HCLK);
        chk("rstseq_rd_ready", HREADYOUT, 1'b1);
        chk("rstseq_rd_data", HRDATA, 32'h0BAD_330D);
        @(posedge HCLK); #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
